// File: rtl/bus_cs_ctrl.sv
// rtl/bus_cs_ctrl.sv - 8088 bus-cycle controller: address decode, chip selects, wait states, bus errors
module bus_cs_ctrl #(
  parameter int ADDR_W   = 20,
  parameter int WAIT_M0  = 0,
  parameter int WAIT_M1  = 2,
  parameter int WAIT_IO0 = 1,
  parameter int WAIT_IO1 = 3,
  parameter int TIMEOUT  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              ale_i,
  input  logic              iom_i,
  input  logic              rd_n_i,
  input  logic              wr_n_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [3:0]        cs_o,
  output logic              ready_o,
  output logic              bus_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR_HOLD, S_WAIT, S_ACTIVE} state_e;

  localparam logic [3:0] W_M0     = 4'(WAIT_M0);
  localparam logic [3:0] W_M1     = 4'(WAIT_M1);
  localparam logic [3:0] W_IO0    = 4'(WAIT_IO0);
  localparam logic [3:0] W_IO1    = 4'(WAIT_IO1);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [1:0]  region_q;
  logic [3:0]  cs_q;
  logic        ready_q;
  logic        bus_err_q;
  logic [3:0]  wcnt_q;
  logic [7:0]  tcnt_q;

  logic [1:0]  region_d;
  logic [3:0]  wait_d;
  logic        one_strobe;
  logic        both_strobe;
  logic        no_strobe;
  logic        unused_addr;

  // Region code doubles as the CS bit index: 0=MEM0, 1=MEM1, 2=IO0, 3=IO1.
  assign region_d    = iom_i ? {1'b1, addr_i[15]} : {1'b0, addr_i[19]};
  assign one_strobe  = rd_n_i ^ wr_n_i;
  assign both_strobe = !rd_n_i && !wr_n_i;
  assign no_strobe   = rd_n_i && wr_n_i;
  assign unused_addr = ^addr_i;

  always_comb begin
    wait_d = W_IO1;
    case (region_q)
      2'd0:    wait_d = W_M0;
      2'd1:    wait_d = W_M1;
      2'd2:    wait_d = W_IO0;
      default: wait_d = W_IO1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      region_q  <= 2'd0;
      cs_q      <= 4'b0000;
      ready_q   <= 1'b1;
      bus_err_q <= 1'b0;
      wcnt_q    <= 4'd0;
      tcnt_q    <= 8'd0;
    end else begin
      bus_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ale_i) begin
            region_q <= region_d;
            cs_q     <= 4'b0001 << region_d;
            tcnt_q   <= 8'd0;
            state_q  <= S_ADDR_HOLD;
          end
        end
        S_ADDR_HOLD: begin
          if (both_strobe) begin
            bus_err_q <= 1'b1;
            cs_q      <= 4'b0000;
            state_q   <= S_IDLE;
          end else if (one_strobe) begin
            if (wait_d == 4'd0) begin
              state_q <= S_ACTIVE;
            end else begin
              wcnt_q  <= wait_d - 4'd1;
              ready_q <= 1'b0;
              state_q <= S_WAIT;
            end
          end else if (tcnt_q == TMO_LAST) begin
            bus_err_q <= 1'b1;
            cs_q      <= 4'b0000;
            state_q   <= S_IDLE;
          end else begin
            tcnt_q <= tcnt_q + 8'd1;
          end
        end
        // Strobe activity is ignored here; the wait count always runs out first.
        S_WAIT: begin
          if (wcnt_q == 4'd0) begin
            ready_q <= 1'b1;
            state_q <= S_ACTIVE;
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        default: begin
          if (no_strobe) begin
            cs_q    <= 4'b0000;
            state_q <= S_IDLE;
          end else if (both_strobe) begin
            bus_err_q <= 1'b1;
            cs_q      <= 4'b0000;
            state_q   <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign cs_o      = cs_q;
  assign ready_o   = ready_q;
  assign bus_err_o = bus_err_q;

endmodule
